// File: rtl/stoch_pool_pkg.sv
// Shared constants and elaboration helpers for the signed stochastic pooling layer.
package stoch_pool_pkg;

    localparam int unsigned MODE_MAX = 0;
    localparam int unsigned MODE_AVG = 1;

    // Signed add clamped to the range of a w-bit two's-complement counter.
    function automatic int sat_add(input int a, input int b, input int unsigned w);
        int hi;
        int lo;
        int s;
        hi = (1 << (w - 1)) - 1;
        lo = -hi - 1;
        s  = a + b;
        if (s > hi) begin
            s = hi;
        end else if (s < lo) begin
            s = lo;
        end
        return s;
    endfunction

    // Pooled output extent; degenerate geometries return 1 and are rejected by the top.
    function automatic int unsigned out_dim(input int unsigned im, input int unsigned pad,
                                            input int unsigned kern, input int unsigned stride);
        if (stride == 0 || kern > im + 2 * pad) begin
            return 1;
        end
        return (im + 2 * pad - kern) / stride + 1;
    endfunction

endpackage

// File: rtl/stoch_signed_window_pool.sv
// One pooling window over N signed bitstreams: counter-tracked argmax or residue-accumulator mean.
module stoch_signed_window_pool
    import stoch_pool_pkg::*;
#(
    parameter int unsigned N            = 4,
    parameter int unsigned MODE         = MODE_MAX,
    parameter int unsigned COUNTER_SIZE = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [N-1:0] i_p,
    input  logic [N-1:0] i_m,
    output logic         o_y_p,
    output logic         o_y_m
);

    logic w_y_p_nxt;
    logic w_y_m_nxt;
    logic r_y_p;
    logic r_y_m;

    if (MODE == MODE_MAX) begin : g_max
        localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

        logic signed [COUNTER_SIZE-1:0] r_cnt [N];
        logic signed [COUNTER_SIZE-1:0] w_best;
        logic [SW-1:0]                  w_argmax;
        logic [SW-1:0]                  r_sel;

        // Strict greater-than keeps the lowest index on ties.
        always_comb begin
            w_best    = r_cnt[0];
            w_argmax  = '0;
            for (int i = 1; i < int'(N); i++) begin
                if (r_cnt[i] > w_best) begin
                    w_best   = r_cnt[i];
                    w_argmax = SW'(i);
                end
            end
            w_y_p_nxt = i_p[r_sel];
            w_y_m_nxt = i_m[r_sel];
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                for (int i = 0; i < int'(N); i++) r_cnt[i] <= '0;
                r_sel <= '0;
            end else if (i_clr) begin
                for (int i = 0; i < int'(N); i++) r_cnt[i] <= '0;
                r_sel <= '0;
            end else if (i_en) begin
                for (int i = 0; i < int'(N); i++) begin
                    r_cnt[i] <= COUNTER_SIZE'(sat_add(int'(r_cnt[i]),
                                                      int'(i_p[i]) - int'(i_m[i]),
                                                      COUNTER_SIZE));
                end
                r_sel <= w_argmax;
            end
        end
    end else begin : g_avg
        localparam int unsigned AW = COUNTER_SIZE + $clog2(N) + 1;

        if (AW > 31) begin : g_bad_width
            $error("stoch_signed_window_pool: accumulator wider than 31 bits");
        end

        logic signed [AW-1:0] r_acc;
        logic signed [AW-1:0] w_acc_nxt;
        int                   w_sum;

        // Emit one output pulse per N units of accumulated signed mass.
        always_comb begin
            w_sum = int'(r_acc);
            for (int i = 0; i < int'(N); i++) begin
                w_sum = w_sum + int'(i_p[i]) - int'(i_m[i]);
            end
            w_y_p_nxt = 1'b0;
            w_y_m_nxt = 1'b0;
            w_acc_nxt = AW'(w_sum);
            if (w_sum >= int'(N)) begin
                w_y_p_nxt = 1'b1;
                w_acc_nxt = AW'(w_sum - int'(N));
            end else if (w_sum <= -int'(N)) begin
                w_y_m_nxt = 1'b1;
                w_acc_nxt = AW'(w_sum + int'(N));
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_acc <= '0;
            end else if (i_clr) begin
                r_acc <= '0;
            end else if (i_en) begin
                r_acc <= w_acc_nxt;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_y_p <= 1'b0;
            r_y_m <= 1'b0;
        end else if (i_clr) begin
            r_y_p <= 1'b0;
            r_y_m <= 1'b0;
        end else if (i_en) begin
            r_y_p <= w_y_p_nxt;
            r_y_m <= w_y_m_nxt;
        end
    end

    assign o_y_p = r_y_p;
    assign o_y_m = r_y_m;

endmodule

// File: rtl/stoch_signed_pool2d.sv
// Signed stochastic 2-D pooling layer: pads and gathers each window, shares one warm-up counter.
module stoch_signed_pool2d
    import stoch_pool_pkg::*;
#(
    parameter  int unsigned IM_HEIGHT    = 4,
    parameter  int unsigned IM_WIDTH     = 4,
    parameter  int unsigned CHANNELS     = 2,
    parameter  int unsigned KERNEL_H     = 2,
    parameter  int unsigned KERNEL_W     = 2,
    parameter  int unsigned PAD_H        = 0,
    parameter  int unsigned PAD_W        = 0,
    parameter  int unsigned STRIDE_H     = 2,
    parameter  int unsigned STRIDE_W     = 2,
    parameter  int unsigned MODE         = MODE_MAX,
    parameter  int unsigned COUNTER_SIZE = 8,
    parameter  int unsigned WARMUP       = 16,
    localparam int unsigned OUT_HEIGHT   = out_dim(IM_HEIGHT, PAD_H, KERNEL_H, STRIDE_H),
    localparam int unsigned OUT_WIDTH    = out_dim(IM_WIDTH, PAD_W, KERNEL_W, STRIDE_W),
    localparam int unsigned IN_BITS      = CHANNELS * IM_HEIGHT * IM_WIDTH,
    localparam int unsigned OUT_BITS     = CHANNELS * OUT_HEIGHT * OUT_WIDTH
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                en,
    input  logic                clr,
    input  logic [IN_BITS-1:0]  x_p,
    input  logic [IN_BITS-1:0]  x_m,
    output logic [OUT_BITS-1:0] y_p,
    output logic [OUT_BITS-1:0] y_m,
    output logic                valid
);

    localparam int unsigned N  = KERNEL_H * KERNEL_W;
    localparam int unsigned WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    if (KERNEL_H > IM_HEIGHT + 2 * PAD_H || KERNEL_W > IM_WIDTH + 2 * PAD_W) begin : g_bad_kernel
        $error("stoch_signed_pool2d: kernel larger than padded image");
    end
    if (STRIDE_H < 1 || STRIDE_W < 1) begin : g_bad_stride
        $error("stoch_signed_pool2d: stride must be at least 1");
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        for (genvar orow = 0; orow < OUT_HEIGHT; orow++) begin : g_row
            for (genvar ocol = 0; ocol < OUT_WIDTH; ocol++) begin : g_col
                localparam int unsigned OB = ch * OUT_HEIGHT * OUT_WIDTH + ocol * OUT_HEIGHT + orow;

                logic [N-1:0] w_p;
                logic [N-1:0] w_m;

                // Window elements are numbered column-major, matching the stream layout.
                for (genvar kc = 0; kc < KERNEL_W; kc++) begin : g_kc
                    for (genvar kr = 0; kr < KERNEL_H; kr++) begin : g_kr
                        localparam int unsigned E  = kc * KERNEL_H + kr;
                        localparam int unsigned PR = orow * STRIDE_H + kr;
                        localparam int unsigned PC = ocol * STRIDE_W + kc;

                        if (PR < PAD_H || PR >= PAD_H + IM_HEIGHT ||
                            PC < PAD_W || PC >= PAD_W + IM_WIDTH) begin : g_pad
                            assign w_p[E] = 1'b0;
                            assign w_m[E] = 1'b0;
                        end else begin : g_real
                            localparam int unsigned XB = ch * IM_HEIGHT * IM_WIDTH +
                                                         (PC - PAD_W) * IM_HEIGHT + (PR - PAD_H);
                            assign w_p[E] = x_p[XB];
                            assign w_m[E] = x_m[XB];
                        end
                    end
                end

                stoch_signed_window_pool #(
                    .N            (N),
                    .MODE         (MODE),
                    .COUNTER_SIZE (COUNTER_SIZE)
                ) u_win (
                    .i_clk   (CLK),
                    .i_rst_n (nRST),
                    .i_en    (en),
                    .i_clr   (clr),
                    .i_p     (w_p),
                    .i_m     (w_m),
                    .o_y_p   (y_p[OB]),
                    .o_y_m   (y_m[OB])
                );
            end
        end
    end

    logic [WW-1:0] r_wcnt;
    logic          r_valid;

    // Warm-up count saturates; valid latches the cycle after the count is reached.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wcnt  <= '0;
            r_valid <= 1'b0;
        end else if (clr) begin
            r_wcnt  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (en && r_wcnt != WW'(WARMUP)) begin
                r_wcnt <= r_wcnt + WW'(1);
            end
            if (r_wcnt == WW'(WARMUP)) begin
                r_valid <= 1'b1;
            end
        end
    end

    assign valid = r_valid;

endmodule

// File: tb/tb_stoch_signed_pool2d.sv
// Directed bench for stoch_signed_pool2d: max, average and padded configurations on a 2x2 image.
module tb_stoch_signed_pool2d;

    logic       CLK;
    logic       nRST;
    logic       en;
    logic       clr;

    logic [3:0] mx_p, mx_m;
    logic [0:0] mx_yp, mx_ym;
    logic       mx_valid;

    logic [3:0] av_p, av_m;
    logic [0:0] av_yp, av_ym;
    logic       av_valid;

    logic [3:0] pd_p, pd_m;
    logic [3:0] pd_yp, pd_ym;
    logic       pd_valid;

    int n_vec;
    int n_err;

    stoch_signed_pool2d #(
        .IM_HEIGHT(2), .IM_WIDTH(2), .CHANNELS(1), .KERNEL_H(2), .KERNEL_W(2),
        .PAD_H(0), .PAD_W(0), .STRIDE_H(1), .STRIDE_W(1), .MODE(0),
        .COUNTER_SIZE(4), .WARMUP(4)
    ) u_max (
        .CLK(CLK), .nRST(nRST), .en(en), .clr(clr),
        .x_p(mx_p), .x_m(mx_m), .y_p(mx_yp), .y_m(mx_ym), .valid(mx_valid)
    );

    stoch_signed_pool2d #(
        .IM_HEIGHT(2), .IM_WIDTH(2), .CHANNELS(1), .KERNEL_H(2), .KERNEL_W(2),
        .PAD_H(0), .PAD_W(0), .STRIDE_H(1), .STRIDE_W(1), .MODE(1),
        .COUNTER_SIZE(8), .WARMUP(0)
    ) u_avg (
        .CLK(CLK), .nRST(nRST), .en(en), .clr(clr),
        .x_p(av_p), .x_m(av_m), .y_p(av_yp), .y_m(av_ym), .valid(av_valid)
    );

    stoch_signed_pool2d #(
        .IM_HEIGHT(2), .IM_WIDTH(2), .CHANNELS(1), .KERNEL_H(2), .KERNEL_W(2),
        .PAD_H(1), .PAD_W(1), .STRIDE_H(2), .STRIDE_W(2), .MODE(1),
        .COUNTER_SIZE(8), .WARMUP(0)
    ) u_pad (
        .CLK(CLK), .nRST(nRST), .en(en), .clr(clr),
        .x_p(pd_p), .x_m(pd_m), .y_p(pd_yp), .y_m(pd_ym), .valid(pd_valid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check4(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        nRST = 1'b0; en = 1'b0; clr = 1'b0;
        mx_p = '0; mx_m = '0; av_p = '0; av_m = '0; pd_p = '0; pd_m = '0;

        #12;
        check1("rst_max_yp", mx_yp[0], 1'b0);
        check1("rst_max_ym", mx_ym[0], 1'b0);
        check1("rst_max_valid", mx_valid, 1'b0);
        check1("rst_avg_valid", av_valid, 1'b0);
        check4("rst_pad_yp", pd_yp, 4'b0000);

        // Max: element 2 always positive; sel settles to 2, output follows one edge later.
        nRST = 1'b1;
        en   = 1'b1;
        mx_p = 4'b0100;
        tick(); check1("max_e1_yp", mx_yp[0], 1'b0); check1("max_e1_valid", mx_valid, 1'b0);
        tick(); check1("max_e2_yp", mx_yp[0], 1'b0);
        tick(); check1("max_e3_yp", mx_yp[0], 1'b1);
        tick(); check1("max_e4_yp", mx_yp[0], 1'b1); check1("max_e4_valid", mx_valid, 1'b0);
        tick(); check1("max_e5_yp", mx_yp[0], 1'b1); check1("max_e5_valid", mx_valid, 1'b1);

        // Stall: inputs change but nothing may move.
        en   = 1'b0;
        mx_p = 4'b0000;
        mx_m = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            tick();
            check1("stall_yp", mx_yp[0], 1'b1);
            check1("stall_ym", mx_ym[0], 1'b0);
            check1("stall_valid", mx_valid, 1'b1);
        end
        en = 1'b1;
        tick();
        check1("resume_ym", mx_ym[0], 1'b1);
        check1("resume_yp", mx_yp[0], 1'b0);

        // Clear beats enable; afterwards sel and counters start from zero.
        clr = 1'b1;
        tick();
        check1("clr_max_yp", mx_yp[0], 1'b0);
        check1("clr_max_ym", mx_ym[0], 1'b0);
        check1("clr_max_valid", mx_valid, 1'b0);
        check1("clr_avg_valid", av_valid, 1'b0);
        clr  = 1'b0;
        mx_p = 4'b0001;
        mx_m = 4'b0000;
        tick(); check1("postclr_a_yp", mx_yp[0], 1'b1); check1("postclr_a_valid", mx_valid, 1'b0);
        tick(); check1("postclr_b_yp", mx_yp[0], 1'b1);

        // All negative except element 3 at zero: sel goes to 3, output silent.
        pulse_clr();
        mx_p = 4'b0000;
        mx_m = 4'b0111;
        tick();
        tick(); check1("neg_e2_ym", mx_ym[0], 1'b1);
        for (int k = 0; k < 10; k++) begin
            tick();
            check1("neg_steady_yp", mx_yp[0], 1'b0);
            check1("neg_steady_ym", mx_ym[0], 1'b0);
        end

        // All equal: tie resolves to element 0.
        pulse_clr();
        mx_m = 4'b1111;
        repeat (3) tick();
        mx_p = 4'b0001;
        mx_m = 4'b1110;
        tick();
        check1("tie_yp", mx_yp[0], 1'b1);
        check1("tie_ym", mx_ym[0], 1'b0);

        // Saturation: cnt0 clamps at 7, so element 1 overtakes only after 4 cycles.
        pulse_clr();
        mx_p = 4'b0001;
        mx_m = 4'b0000;
        repeat (20) tick();
        check1("sat_hold_yp", mx_yp[0], 1'b1);
        mx_p = 4'b0010;
        mx_m = 4'b0001;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check1("sat_old_ym", mx_ym[0], 1'b1);
            check1("sat_old_yp", mx_yp[0], 1'b0);
        end
        tick();
        check1("sat_new_yp", mx_yp[0], 1'b1);
        check1("sat_new_ym", mx_ym[0], 1'b0);
        mx_p = 4'b0000;
        mx_m = 4'b0000;

        // Average: mean 0.5 gives alternating pulses; WARMUP=0 is valid right after clear.
        pulse_clr();
        av_p = 4'b0011;
        tick(); check1("avg_valid0", av_valid, 1'b1); check1("avg_e1_yp", av_yp[0], 1'b0);
        tick(); check1("avg_e2_yp", av_yp[0], 1'b1);
        tick(); check1("avg_e3_yp", av_yp[0], 1'b0);
        tick(); check1("avg_e4_yp", av_yp[0], 1'b1);
        tick(); check1("avg_e5_yp", av_yp[0], 1'b0);
        tick(); check1("avg_e6_yp", av_yp[0], 1'b1);
        av_p = 4'b0000;
        av_m = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            tick();
            check1("avg_neg_ym", av_ym[0], 1'b1);
            check1("avg_neg_yp", av_yp[0], 1'b0);
        end
        av_m = 4'b0000;

        // Padding: each corner window sees one real pixel, one pulse per four cycles.
        pulse_clr();
        pd_p = 4'b0010;
        pd_m = 4'b0100;
        tick(); tick(); tick();
        check4("pad_map_e3_yp", pd_yp, 4'b0000);
        tick();
        check4("pad_map_e4_yp", pd_yp, 4'b0010);
        check4("pad_map_e4_ym", pd_ym, 4'b0100);
        tick();
        check4("pad_map_e5_yp", pd_yp, 4'b0000);
        pulse_clr();
        pd_p = 4'b1111;
        pd_m = 4'b0000;
        tick(); tick(); tick();
        check4("pad_all_e3_yp", pd_yp, 4'b0000);
        tick();
        check4("pad_all_e4_yp", pd_yp, 4'b1111);
        check1("pad_valid", pd_valid, 1'b1);

        // Asynchronous reset mid-cycle clears outputs without waiting for an edge.
        pulse_clr();
        mx_p = 4'b0001;
        av_m = 4'b1111;
        repeat (6) tick();
        check1("pre_arst_max_yp", mx_yp[0], 1'b1);
        check1("pre_arst_max_valid", mx_valid, 1'b1);
        check1("pre_arst_avg_ym", av_ym[0], 1'b1);
        #2;
        nRST = 1'b0;
        #1;
        check1("arst_max_yp", mx_yp[0], 1'b0);
        check1("arst_max_valid", mx_valid, 1'b0);
        check1("arst_avg_ym", av_ym[0], 1'b0);
        check1("arst_avg_valid", av_valid, 1'b0);
        #10;
        nRST = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
